seven_segment_scan: RTL
=======================

Name: seven_segment_scan

Overview:
- Parametrised multiplexed seven-segment driver for DIGITS common-anode/cathode digits. It scans one digit at a time.
- Adds four features: a tear-free double-buffered display value, per-digit PWM brightness, an optional leading-zero blanking mode, and configurable output polarity.
- Sits between the CPU-side display register (the value and load source) and the board pins, clocked by displayClk.

Parameters:
- DIGITS, 4, number of digits scanned (1..16); value width is 4*DIGITS.
- BRIGHT_W, 4, width of brightness and of the in-slot PWM phase counter; slot = 2^BRIGHT_W phases.
- PRESCALE, 1, displayClk cycles per PWM phase (>=1).
- SEG_ACTIVE_LOW, 0, 1 inverts all seg outputs.
- DIG_ACTIVE_LOW, 0, 1 inverts all dig outputs.

Ports:
- displayClk  in  1  display scan clock.
- rst  in  1  synchronous active-high reset, sampled on displayClk.
- load  in  1  single-cycle strobe; captures value/dots into the pending buffer.
- value  in  4*DIGITS  hex nibbles; nibble i goes to digit i (nibble 0 = rightmost).
- dots  in  DIGITS  decimal point per digit.
- blank_lz  in  1  1 = blank leading zero digits.
- brightness  in  BRIGHT_W  duty control; sampled live every cycle.
- dig  out  DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW).
- seg  out  8  {dp,g,f,e,d,c,b,a}; polarity per SEG_ACTIVE_LOW.
- frame  out  1  one-cycle pulse marking the start of each scan frame.

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs: dig all inactive, seg all inactive (0x00 before polarity), frame=0.
  - Internal state: shadow and pending buffers cleared to 0, pending_valid=0, digit index=0, phase=0, prescale count=0.
- Counters:
  - The prescale counter runs 0..PRESCALE-1. Phase advances when it wraps (a "tick").
  - Phase runs 0..2^BRIGHT_W-1. The digit index advances when phase wraps on a tick.
  - The digit index runs 0..DIGITS-1 and wraps to 0. A frame is DIGITS*2^BRIGHT_W*PRESCALE cycles.
- Outputs are registered, with one cycle of latency from counter state:
  - The first edge after rst falls shows digit 0, phase 0. dig[0] is active, since phase 0 always passes the duty check.
- PWM:
  - The current digit's dig bit is active iff phase <= brightness; all other dig bits are inactive.
  - brightness=0 gives 1/2^BRIGHT_W duty; brightness=all-ones gives full duty.
  - seg is driven with the digit's pattern regardless of PWM.
- Decode (nibble to seg[6:0] before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - seg[7] = shadow dot of the current digit.
- Leading-zero blanking: when blank_lz=1, digit i>0 has seg[6:0]=0 if all shadow nibbles i..DIGITS-1 are 0.
  - Digit 0 is never blanked.
  - The dp is still shown on a blanked digit.
  - A value of 0 displays a single "0".
- Double buffering:
  - load=1 writes value/dots to the pending buffer and sets pending_valid.
  - The display reads only the shadow buffer.
  - At the frame boundary (the tick where the digit index wraps DIGITS-1 to 0), if pending_valid, shadow <= pending and pending_valid clears.
  - Multiple loads within one frame: the last one wins.
  - load in the same cycle as the boundary: that cycle's value/dots go straight to shadow, and pending_valid stays 0.
- frame is 1 on the output cycle that shows digit 0, phase 0, prescale count 0. This includes the first cycle after reset.
- Reset mid-frame: counters and buffers restart; any pending load is discarded.
- DIGITS=1: the index stays 0; a frame boundary occurs every phase wrap.

Test Plan:
- DIGITS=4, BRIGHT_W=2, PRESCALE=1, brightness=3, load 0x1234 before the first boundary:
  - After the first frame boundary, dig cycles 0001 (seg 5B for nibble 4? no: nibble0=4 -> 66), 0010 (4F), 0100 (5B), 1000 (06).
  - Each digit lasts 4 cycles; frame pulses every 16 cycles.
- Same configuration, brightness=1: each digit's dig bit is active on phases 0-1 and inactive on phases 2-3 (50% duty). seg is stable across all 4 phases.
- blank_lz=1:
  - value 0x0050: digits 3,2 give seg[6:0]=0, digit 1 gives 6D, digit 0 gives 3F.
  - value 0x0000: only digit 0 shows 3F.
  - dots=4'b1000 with value 0x0050: digit 3 seg=0x80.
- Tear-free update: load 0xAAAA mid-frame, then load 0xBBBB two cycles later. The current frame still shows the old value; the next frame shows 0xBBBB (7C) on all digits. 0xAAAA is never displayed.
- load coincident with the frame-boundary cycle, value 0xCCCC: the frame starting next shows 39 on every digit.
- SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, assert rst mid-frame:
  - During reset: dig=1111, seg=FF.
  - First edge after release: dig=1110 with frame=1, and digit 0 shows nibble 0 of a cleared shadow ("0", seg=0xC0).

Source files
------------

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner: one digit per slot, PWM brightness per slot,
// tear-free double-buffered value, optional leading-zero blanking, selectable polarity.
module seven_segment_scan #(
  parameter int DIGITS         = 4,
  parameter int BRIGHT_W       = 4,
  parameter int PRESCALE       = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                displayClk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dots,
  input  logic                blank_lz,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [DIGITS-1:0]   dig,
  output logic [7:0]          seg,
  output logic                frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0]    LAST_PRE   = PRE_W'(PRESCALE - 1);
  localparam logic [BRIGHT_W-1:0] LAST_PHASE = '1;
  localparam logic [7:0]          SEG_INV    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0]   DIG_INV    = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dots_q, shadow_dots_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dots_q, pend_dots_d;
  logic                pend_valid_q, pend_valid_d;

  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_q, frame_d;

  logic                tick, phase_wrap, boundary;
  logic                duty_on, zero_above, cur_blank, cur_dot;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   dig_raw;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Scan counters: prescale -> phase within slot -> digit index.
  always_comb begin
    tick       = (pre_q == LAST_PRE);
    phase_wrap = tick && (phase_q == LAST_PHASE);
    boundary   = phase_wrap && (idx_q == LAST_IDX);
    pre_d      = tick ? '0 : pre_q + 1'b1;
    phase_d    = tick ? phase_q + 1'b1 : phase_q;
    idx_d      = idx_q;
    if (phase_wrap) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses the pending buffer entirely.
  always_comb begin
    shadow_val_d  = shadow_val_q;
    shadow_dots_d = shadow_dots_q;
    pend_val_d    = pend_val_q;
    pend_dots_d   = pend_dots_q;
    pend_valid_d  = pend_valid_q;
    if (load) begin
      pend_val_d   = value;
      pend_dots_d  = dots;
      pend_valid_d = 1'b1;
    end
    if (boundary) begin
      pend_valid_d = 1'b0;
      if (load) begin
        shadow_val_d  = value;
        shadow_dots_d = dots;
      end else if (pend_valid_q) begin
        shadow_val_d  = pend_val_q;
        shadow_dots_d = pend_dots_q;
      end
    end
  end

  // Walk from the top digit down so zero_above covers digits i..DIGITS-1.
  always_comb begin
    duty_on    = (phase_q <= brightness);
    zero_above = 1'b1;
    cur_blank  = 1'b0;
    cur_dot    = 1'b0;
    cur_nib    = 4'h0;
    dig_raw    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (shadow_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib    = shadow_val_q[4*i +: 4];
        cur_dot    = shadow_dots_q[i];
        cur_blank  = blank_lz & (i != 0) & zero_above;
        dig_raw[i] = duty_on;
      end
    end
    seg_d   = {cur_dot, cur_blank ? 7'h00 : decode(cur_nib)} ^ SEG_INV;
    dig_d   = dig_raw ^ DIG_INV;
    frame_d = (idx_q == '0) && (phase_q == '0) && (pre_q == '0);
  end

  // NOTE: the display buffers are small flop arrays, not RAM, so they take the
  // synchronous reset like every other register here.
  always_ff @(posedge displayClk) begin
    if (rst) begin
      pre_q         <= '0;
      phase_q       <= '0;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_dots_q <= '0;
      pend_val_q    <= '0;
      pend_dots_q   <= '0;
      pend_valid_q  <= 1'b0;
      dig_q         <= DIG_INV;
      seg_q         <= SEG_INV;
      frame_q       <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dots_q <= shadow_dots_d;
      pend_val_q    <= pend_val_d;
      pend_dots_q   <= pend_dots_d;
      pend_valid_q  <= pend_valid_d;
      dig_q         <= dig_d;
      seg_q         <= seg_d;
      frame_q       <= frame_d;
    end
  end

  assign dig   = dig_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule
